instr_fetch_ctrl: RTL

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/riscv_defines.sv | 29 ++
 rtl/fetch_fifo.sv | 83 ++++++++
 rtl/instr_fetch_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/riscv_defines.sv
// ----------------------------------------------------------------------------
// riscv_defines
// Shared core-wide definitions: datapath widths, the fetch controller state
// encoding and the {word, address} entry that the fetch FIFO carries.
// ----------------------------------------------------------------------------
package riscv_defines;

    localparam int RISCV_WORD_WIDTH = 32;
    localparam int RISCV_ADDR_WIDTH = 32;

    // RUN   : normal fetching, responses are forwarded.
    // FLUSH : waiting for stale responses of a redirected stream to drain.
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [RISCV_WORD_WIDTH-1:0] instr;
        logic [RISCV_ADDR_WIDTH-1:0] addr;
    } fetch_entry_t;

    function automatic logic [RISCV_ADDR_WIDTH-1:0] word_align(
        input logic [RISCV_ADDR_WIDTH-1:0] a
    );
        return {a[RISCV_ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding fetched words until the realign buffer
// accepts them. Registered output (head entry), no write-to-read bypass.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   clear_i  in   synchronous flush, same effect as rst
//   push_i   in   write data_i at the tail
//   data_i   in   entry to write
//   pop_i    in   drop the head entry (ignored when empty)
//   data_o   out  head entry
//   full_o   out  DEPTH entries held
//   empty_o  out  no entries held
//   count_o  out  number of entries held
// ----------------------------------------------------------------------------
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o    = (r_count == CW'(DEPTH));
    assign empty_o   = (r_count == '0);
    assign count_o   = r_count;
    assign data_o    = r_mem[r_rd_ptr];
    assign w_do_push = push_i && !clear_i && !rst;
    assign w_do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= data_i;
    end

    // The controller's issue limit must make a push into a full FIFO
    // impossible unless the head leaves in the same cycle.
    always_ff @(posedge clk) begin
        if (w_do_push) assert (!full_o || w_do_pop);
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// instr_fetch_ctrl
// Instruction fetch controller: issues word-aligned requests to instruction
// memory, tracks responses in flight, queues returned words for the realign
// buffer and discards stale responses after a redirect.
//
// Ports:
//   clk              in   clock
//   rst              in   synchronous active-high reset
//   redirect_i       in   branch/jump/exception redirect strobe
//   redirect_addr_i  in   redirect target (halfword aligned)
//   instr_req_o      out  memory request
//   instr_addr_o     out  word-aligned request address
//   instr_gnt_i      in   request accepted
//   instr_rvalid_i   in   response valid (in order, never stalled)
//   instr_rdata_i    in   response word
//   fetch_valid_o    out  word available for the realign buffer
//   fetch_instr_o    out  word to the realign buffer
//   fetch_addr_o     out  word address of fetch_instr_o
//   buf_full_i       in   realign buffer full
//   buf_clear_o      out  realign buffer clear
//   buf_offset_o     out  realign buffer read offset (halfword select)
// ----------------------------------------------------------------------------
module instr_fetch_ctrl
    import riscv_defines::*;
#(
    parameter logic [RISCV_ADDR_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int                          FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        redirect_i,
    input  logic [RISCV_ADDR_WIDTH-1:0] redirect_addr_i,
    output logic                        instr_req_o,
    output logic [RISCV_ADDR_WIDTH-1:0] instr_addr_o,
    input  logic                        instr_gnt_i,
    input  logic                        instr_rvalid_i,
    input  logic [RISCV_WORD_WIDTH-1:0] instr_rdata_i,
    output logic                        fetch_valid_o,
    output logic [RISCV_WORD_WIDTH-1:0] fetch_instr_o,
    output logic [RISCV_ADDR_WIDTH-1:0] fetch_addr_o,
    input  logic                        buf_full_i,
    output logic                        buf_clear_o,
    output logic                        buf_offset_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [RISCV_ADDR_WIDTH-1:0] ADDR_STEP = RISCV_ADDR_WIDTH'(4);

    fetch_state_e                r_state,  w_state_nxt;
    logic [RISCV_ADDR_WIDTH-1:0] r_req_addr,  w_req_addr_nxt;
    logic [RISCV_ADDR_WIDTH-1:0] r_resp_addr, w_resp_addr_nxt;
    logic [CW-1:0]               r_outstanding, w_outstanding_nxt;
    logic [CW:0]                 w_slots_used;
    logic                        w_fire;
    logic                        w_push;
    logic                        w_pop;
    logic [CW-1:0]               w_fifo_count;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    fetch_entry_t                w_push_entry;
    fetch_entry_t                w_head;
    logic                        w_unused;

    always_comb begin
        instr_req_o       = 1'b0;
        w_fire            = 1'b0;
        w_push            = 1'b0;
        w_pop             = 1'b0;
        w_outstanding_nxt = r_outstanding;
        w_state_nxt       = r_state;
        w_req_addr_nxt    = r_req_addr;
        w_resp_addr_nxt   = r_resp_addr;

        // Every request in flight has a FIFO slot reserved for its response,
        // so responses (which cannot be stalled) always have somewhere to go.
        w_slots_used = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
        instr_req_o  = !rst && (r_state == RUN) && !redirect_i
                       && (w_slots_used < (CW+1)'(FIFO_DEPTH));
        w_fire       = instr_req_o && instr_gnt_i;

        // Responses are forwarded only in RUN; in FLUSH, and in the redirect
        // cycle itself, they belong to the abandoned stream.
        w_push = !rst && (r_state == RUN) && !redirect_i && instr_rvalid_i;

        fetch_valid_o = !rst && !w_fifo_empty;
        w_pop         = fetch_valid_o && !buf_full_i && !redirect_i;

        if (w_fire && !instr_rvalid_i)
            w_outstanding_nxt = r_outstanding + 1'b1;
        else if (!w_fire && instr_rvalid_i && (r_outstanding != '0))
            w_outstanding_nxt = r_outstanding - 1'b1;

        if (redirect_i)
            w_state_nxt = (w_outstanding_nxt != '0) ? FLUSH : RUN;
        else if ((r_state == FLUSH) && (w_outstanding_nxt == '0))
            w_state_nxt = RUN;

        if (redirect_i) begin
            w_req_addr_nxt  = word_align(redirect_addr_i);
            w_resp_addr_nxt = word_align(redirect_addr_i);
        end else begin
            if (w_fire) w_req_addr_nxt  = r_req_addr + ADDR_STEP;
            if (w_push) w_resp_addr_nxt = r_resp_addr + ADDR_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_outstanding <= '0;
            r_req_addr    <= word_align(BOOT_ADDR);
            r_resp_addr   <= word_align(BOOT_ADDR);
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_req_addr    <= w_req_addr_nxt;
            r_resp_addr   <= w_resp_addr_nxt;
        end
    end

    assign w_push_entry = '{instr: instr_rdata_i, addr: r_resp_addr};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (redirect_i),
        .push_i  (w_push),
        .data_i  (w_push_entry),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    assign instr_addr_o  = word_align(r_req_addr);
    assign fetch_instr_o = w_head.instr;
    assign fetch_addr_o  = w_head.addr;
    // The realign buffer is also cleared while the core is held in reset.
    assign buf_clear_o   = redirect_i || rst;
    assign buf_offset_o  = !rst && redirect_addr_i[1];

    assign w_unused = redirect_addr_i[0] ^ w_fifo_full;

endmodule
